// File: rtl/addsub_digit_serial_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
// master: operand producer and result consumer; slave: the arithmetic unit.
interface addsub_digit_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             K;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;
  logic             Zero;

  modport master (
    output in_valid, A, B, K, Cin, out_ready,
    input  in_ready, out_valid, S, Cout, Ovf, Zero
  );

  modport slave (
    input  in_valid, A, B, K, Cin, out_ready,
    output in_ready, out_valid, S, Cout, Ovf, Zero
  );
endinterface

// File: rtl/addsub_digit_serial.sv
// Digit-serial WIDTH-bit adder/subtractor: DIGIT bits per clock, LSB digit
// first, with valid/ready handshakes and carry/overflow/zero flags.
// Optional macro ADDSUB_SAT_EN: on signed overflow S saturates to 0x7F..F or
// 0x80..0 depending on the MSB of operand A (flags stay on the raw sum except
// Zero, which follows the delivered S).
module addsub_digit_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  addsub_digit_serial_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   res_r;
  logic               carry_r;
  logic [CW-1:0]      cnt_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   s_r;
  logic               cout_r;
  logic               ovf_r;
  logic               zero_r;

  logic [DIGIT:0]       digit_sum_s;
  logic [WIDTH+DIGIT-1:0] res_ext_s;
  logic [WIDTH-1:0]     next_res_s;
  logic                 msb_cin_s;
  logic                 ovf_s;
  logic                 a_msb_s;
  logic [WIDTH-1:0]     final_s_s;

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  // One digit of the ripple sum plus the result-register shift and flag terms.
  always_comb begin
    digit_sum_s = {1'b0, a_sh_r[DIGIT-1:0]} + {1'b0, b_sh_r[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_r};
    res_ext_s   = {digit_sum_s[DIGIT-1:0], res_r};
    next_res_s  = res_ext_s[WIDTH+DIGIT-1:DIGIT];
    // Carry into the top bit of this digit, recovered from its sum bit; on the
    // last digit this is the carry into the result MSB.
    msb_cin_s   = a_sh_r[DIGIT-1] ^ b_sh_r[DIGIT-1] ^ digit_sum_s[DIGIT-1];
    ovf_s       = msb_cin_s ^ digit_sum_s[DIGIT];
    // On the last digit the operand-A MSB sits at the top of the current digit.
    a_msb_s     = a_sh_r[DIGIT-1];
`ifdef ADDSUB_SAT_EN
    if (ovf_s) begin
      final_s_s = {a_msb_s, {(WIDTH-1){~a_msb_s}}};
    end else begin
      final_s_s = next_res_s;
    end
`else
    final_s_s = next_res_s;
`endif
  end

  // Control FSM, operand shift registers and registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_sh_r      <= {WIDTH{1'b0}};
      b_sh_r      <= {WIDTH{1'b0}};
      res_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      s_r         <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_r     <= bus.A;
            b_sh_r     <= bus.B ^ {WIDTH{bus.K}};
            carry_r    <= bus.Cin;
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            state_r    <= IDLE;
          end
        end
        RUN: begin
          a_sh_r  <= a_sh_r >> DIGIT;
          b_sh_r  <= b_sh_r >> DIGIT;
          carry_r <= digit_sum_s[DIGIT];
          res_r   <= next_res_s;
          if (cnt_r == LAST_CNT) begin
            cnt_r       <= {CW{1'b0}};
            s_r         <= final_s_s;
            cout_r      <= digit_sum_s[DIGIT];
            ovf_r       <= ovf_s;
            zero_r      <= is_zero(final_s_s);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r       <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.S         = s_r;
  assign bus.Cout      = cout_r;
  assign bus.Ovf       = ovf_r;
  assign bus.Zero      = zero_r;

endmodule
